// File: rtl/rob_table_pkg.sv
// Shared types and constants for the reorder buffer: entry layout, tag width,
// and the circular tag-advance helper (tags run 1..num_tags, never 0).
package rob_table_pkg;

    localparam int ROB_TAG_W = 4;
    localparam int DATA_W    = 32;
    localparam int REG_W     = 5;

    typedef struct packed {
        logic              busy;
        logic              ready;
        logic              writes;
        logic [REG_W-1:0]  dest;
        logic              is_branch;
        logic              mispredict;
        logic [DATA_W-1:0] value;
    } rob_entry_t;

    function automatic logic [ROB_TAG_W-1:0] next_tag(input logic [ROB_TAG_W-1:0] tag,
                                                      input int                   num_tags);
        return (int'(tag) == num_tags) ? ROB_TAG_W'(1) : tag + 1'b1;
    endfunction

endpackage

// File: rtl/rob_entry.sv
// One reorder-buffer slot. Clear beats allocate beats CDB write; a CDB write
// only lands on a busy slot so stale broadcasts cannot resurrect a free tag.
module rob_entry
    import rob_table_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              alloc,
    input  logic              alloc_writes,
    input  logic [REG_W-1:0]  alloc_dest,
    input  logic              alloc_is_branch,
    input  logic              cdb_wr,
    input  logic [DATA_W-1:0] cdb_value,
    input  logic              cdb_mispredict,
    input  logic              clr,
    output rob_entry_t        entry
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            entry <= '0;
        end else if (clr) begin
            entry <= '0;
        end else if (alloc) begin
            entry <= '{busy: 1'b1, ready: 1'b0, writes: alloc_writes, dest: alloc_dest,
                       is_branch: alloc_is_branch, mispredict: 1'b0, value: '0};
        end else if (cdb_wr && entry.busy) begin
            entry.ready      <= 1'b1;
            entry.value      <= cdb_value;
            entry.mispredict <= cdb_mispredict;
        end
    end

endmodule

// File: rtl/rob_table.sv
// Reorder buffer: circular queue of NUM_TAGS entries with in-order commit and
// flush on a committed mispredicted branch. Define ROB_OPERAND_READ_EN to add
// the Q_j/Q_k operand read ports with same-cycle CDB bypass.
module rob_table
    import rob_table_pkg::*;
#(
    parameter int NUM_TAGS = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 issue_valid,
    input  logic                 issue_writes,
    input  logic [REG_W-1:0]     issue_dest,
    input  logic                 issue_is_branch,
    output logic [ROB_TAG_W-1:0] issue_ROB,
    output logic                 rob_full,
    input  logic                 cdb_valid,
    input  logic [ROB_TAG_W-1:0] cdb_ROB,
    input  logic [DATA_W-1:0]    cdb_value,
    input  logic                 cdb_mispredict,
    output logic                 commit_valid,
    output logic [ROB_TAG_W-1:0] commit_ROB,
    output logic [REG_W-1:0]     commit_dest,
    output logic [DATA_W-1:0]    commit_value,
    output logic                 RegWrite,
    output logic                 flush
`ifdef ROB_OPERAND_READ_EN
    ,
    input  logic [ROB_TAG_W-1:0] Q_j,
    input  logic [ROB_TAG_W-1:0] Q_k,
    output logic [DATA_W-1:0]    V_j,
    output logic [DATA_W-1:0]    V_k,
    output logic                 j_ready,
    output logic                 k_ready
`endif
);

    localparam int CNT_W = $clog2(NUM_TAGS + 1);
    localparam int SLOTS = 1 << ROB_TAG_W;

    // Full tag space is decoded; slot 0 and slots above NUM_TAGS read as empty.
    rob_entry_t           entries [0:SLOTS-1];
    logic [ROB_TAG_W-1:0] head, tail;
    logic [CNT_W-1:0]     count;
    logic                 do_alloc;

    assign issue_ROB    = tail;
    assign rob_full     = (count == CNT_W'(NUM_TAGS));
    assign commit_valid = (count != '0) && entries[head].busy && entries[head].ready;
    assign commit_ROB   = commit_valid ? head : '0;
    assign commit_dest  = commit_valid ? entries[head].dest : '0;
    assign commit_value = commit_valid ? entries[head].value : '0;
    assign RegWrite     = commit_valid && entries[head].writes && (entries[head].dest != '0);
    assign flush        = commit_valid && entries[head].is_branch && entries[head].mispredict;
    assign do_alloc     = issue_valid && !rob_full && !flush;

    for (genvar t = 0; t < SLOTS; t++) begin : g_ent
        if (t >= 1 && t <= NUM_TAGS) begin : g_slot
            rob_entry u_entry (
                .clk             (clk),
                .reset           (reset),
                .alloc           (do_alloc && (tail == ROB_TAG_W'(t))),
                .alloc_writes    (issue_writes),
                .alloc_dest      (issue_dest),
                .alloc_is_branch (issue_is_branch),
                .cdb_wr          (cdb_valid && (cdb_ROB == ROB_TAG_W'(t))),
                .cdb_value       (cdb_value),
                .cdb_mispredict  (cdb_mispredict),
                .clr             (flush || (commit_valid && (head == ROB_TAG_W'(t)))),
                .entry           (entries[t])
            );
        end else begin : g_tie
            assign entries[t] = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head  <= ROB_TAG_W'(1);
            tail  <= ROB_TAG_W'(1);
            count <= '0;
        end else if (flush) begin
            head  <= ROB_TAG_W'(1);
            tail  <= ROB_TAG_W'(1);
            count <= '0;
        end else begin
            if (commit_valid) head <= next_tag(head, NUM_TAGS);
            if (do_alloc)     tail <= next_tag(tail, NUM_TAGS);
            count <= count + CNT_W'(do_alloc) - CNT_W'(commit_valid);
        end
    end

`ifdef ROB_OPERAND_READ_EN
    // Tag 0 means "no producer"; a broadcast to a busy tag this cycle wins over the stored value.
    always_comb begin
        j_ready = 1'b1;
        V_j     = '0;
        if (Q_j != '0) begin
            j_ready = entries[Q_j].ready;
            V_j     = entries[Q_j].value;
            if (cdb_valid && (cdb_ROB == Q_j) && entries[Q_j].busy) begin
                j_ready = 1'b1;
                V_j     = cdb_value;
            end
        end
    end

    always_comb begin
        k_ready = 1'b1;
        V_k     = '0;
        if (Q_k != '0) begin
            k_ready = entries[Q_k].ready;
            V_k     = entries[Q_k].value;
            if (cdb_valid && (cdb_ROB == Q_k) && entries[Q_k].busy) begin
                k_ready = 1'b1;
                V_k     = cdb_value;
            end
        end
    end
`endif

endmodule
